// File: rtl/vga_fb_scanout_if.sv
// Writer request port and single-port SRAM bus shared by the framebuffer scanout.
// master = writer/SRAM side, slave = scanout controller.
interface vga_fb_scanout_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 8
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_we;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;

   modport master (
      output wr_valid, wr_addr, wr_data, sram_rdata,
      input  wr_ready, sram_addr, sram_we, sram_wdata
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, sram_rdata,
      output wr_ready, sram_addr, sram_we, sram_wdata
   );
endinterface

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout: arbitrates one SRAM between linear display prefetch and a
// pixel writer, and holds vga_sync off until the prefetch FIFO is primed.
//
//   state | meaning
//   PRIME | filling prefetch FIFO, vga_enable low
//   RUN   | display running, vga_enable high (left only by reset)
module vga_fb_scanout #(
   parameter int H_VISIBLE  = 640,
   parameter int V_VISIBLE  = 480,
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int LOW_WATER  = 8,
   parameter int PREFILL    = 12
) (
   input  logic              clk,
   input  logic              reset,
   vga_fb_scanout_if.slave   bus,
   output logic              vga_enable,
   input  logic              vga_visible,
   output logic [DATA_W-1:0] pixel,
   output logic              pixel_valid,
   output logic              underflow
);
   localparam int FRAME = H_VISIBLE * V_VISIBLE;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;

   typedef enum logic {PRIME, RUN} state_t;

   state_t            state;
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic [CW-1:0]     occ;
   logic              inflight;
   logic [ADDR_W-1:0] fetch_addr;
   logic              do_read;
   logic              do_write;
   logic              pop_ok;

   // Reads in flight count against capacity so the FIFO can never overflow.
   always_comb begin
      occ      = count + CW'(inflight);
      do_read  = 1'b0;
      do_write = 1'b0;
      if (reset) begin
         if (occ < CW'(LOW_WATER))
            do_read = 1'b1;
         else if (bus.wr_valid)
            do_write = 1'b1;
         else if (occ < CW'(FIFO_DEPTH))
            do_read = 1'b1;
      end
   end

   assign bus.wr_ready   = do_write;
   assign bus.sram_we    = do_write;
   assign bus.sram_addr  = do_write ? bus.wr_addr : (do_read ? fetch_addr : '0);
   assign bus.sram_wdata = do_write ? bus.wr_data : '0;
   assign pop_ok         = vga_visible && (count != '0);

   always_ff @(posedge clk) begin
      if (reset && inflight)
         fifo_mem[wr_ptr] <= bus.sram_rdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= PRIME;
         vga_enable  <= 1'b0;
         pixel       <= '0;
         pixel_valid <= 1'b0;
         underflow   <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         inflight    <= 1'b0;
         fetch_addr  <= '0;
      end else begin
         inflight <= do_read;
         if (do_read)
            fetch_addr <= (fetch_addr == ADDR_W'(FRAME - 1)) ? '0 : fetch_addr + ADDR_W'(1);
         if (inflight)
            wr_ptr <= wr_ptr + PW'(1);

         // An empty pop outputs black and leaves pointers alone; alignment is lost until reset.
         pixel_valid <= vga_visible;
         if (vga_visible) begin
            if (pop_ok) begin
               pixel  <= fifo_mem[rd_ptr];
               rd_ptr <= rd_ptr + PW'(1);
            end else begin
               pixel     <= '0;
               underflow <= 1'b1;
            end
         end
         count <= count + CW'(inflight) - CW'(pop_ok);

         case (state)
            PRIME: begin
               vga_enable <= 1'b0;
               if (count >= CW'(PREFILL)) begin
                  state      <= RUN;
                  vga_enable <= 1'b1;
               end
            end
            RUN:     vga_enable <= 1'b1;
            default: state <= PRIME;
         endcase
      end
   end
endmodule
